// File: rtl/card_filler_pkg.sv
// card_filler_pkg: shared definitions for the bingo card filler.
//   - default geometry (DATA_WIDTH, ADDR_WIDTH, NUM_ENTRIES, MAX_NUMBER)
//   - Galois LFSR tap constant and next-state helper
//   - filler state type
package card_filler_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_NUM_ENTRIES = 16;
  localparam int DEF_MAX_NUMBER  = 99;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_CHECK,
    ST_WRITE,
    ST_DONE
  } fill_state_t;

  // 8-bit Galois right-shift step; period 255, never reaches 0 from a non-zero state.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {1'b0, l[7:1]} ^ (l[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/card_filler_if.sv
// card_filler_if: RAM write/read port shared between the card filler and the game FSM.
//   ram_addr         address (read while scanning, write while writing)
//   ram_write_en     one-cycle write strobe
//   ram_write_number write data, valid with ram_write_en
//   ram_read_number  asynchronous read data for ram_addr
// Modports: master = filler side, slave = RAM side.
interface card_filler_if
  import card_filler_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_write_en;
  logic [DATA_WIDTH-1:0] ram_write_number;
  logic [DATA_WIDTH-1:0] ram_read_number;

  modport master (
    output ram_addr,
    output ram_write_en,
    output ram_write_number,
    input  ram_read_number
  );

  modport slave (
    input  ram_addr,
    input  ram_write_en,
    input  ram_write_number,
    output ram_read_number
  );

endinterface

// File: rtl/card_filler_lfsr.sv
// bingo_lfsr: 8-bit Galois LFSR with enable and synchronous load.
//   clk, rstn   clock, async active-low reset (value <= SEED)
//   en          advance one step this cycle
//   load        load load_value this cycle (wins over en)
//   load_value  value to load
//   value       current LFSR state
module bingo_lfsr
  import card_filler_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= SEED;
    end else if (load) begin
      value <= load_value;
    end else if (en) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/card_filler.sv
// card_filler: fills every RAM slot with a unique pseudo-random number in 1..MAX_NUMBER.
// Each accepted candidate is compared against all slots already written
// (one slot per cycle) before it is stored.
//   clk, rstn    clock, async active-low reset
//   start_fill   level, honoured only in IDLE and DONE
//   seed         (only with CARD_FILLER_SEED_IN_EN) LFSR load value on start; 0 selects LFSR_SEED
//   ram          card_filler_if master: addr / write strobe / write data / async read data
//   busy         high while filling (GEN, CHECK, WRITE)
//   fill_done    high in DONE
// Build option: define CARD_FILLER_SEED_IN_EN to add the seed input; otherwise the
// LFSR free-runs from reset and start timing selects the card.
module card_filler
  import card_filler_pkg::*;
#(
  parameter int         DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int         ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int         NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int         MAX_NUMBER  = DEF_MAX_NUMBER,
  parameter logic [7:0] LFSR_SEED   = 8'h01
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_fill,
`ifdef CARD_FILLER_SEED_IN_EN
  input  logic [7:0] seed,
`endif
  card_filler_if.master ram,
  output logic       busy,
  output logic       fill_done
);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("card_filler: DATA_WIDTH must be 8");
  end
  if (NUM_ENTRIES != (1 << ADDR_WIDTH)) begin : g_bad_entries
    $error("card_filler: NUM_ENTRIES must equal 2**ADDR_WIDTH");
  end
  if ((MAX_NUMBER < NUM_ENTRIES) || (MAX_NUMBER > 255)) begin : g_bad_max
    $error("card_filler: MAX_NUMBER out of range");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("card_filler: LFSR_SEED must be non-zero");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ENTRIES - 1);

  fill_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [ADDR_WIDTH-1:0] scan_idx_q, scan_idx_d;
  logic [DATA_WIDTH-1:0] cand_q, cand_d;

  logic       lfsr_en;
  logic       lfsr_load;
  logic [7:0] lfsr_load_value;
  logic [7:0] lfsr_q;
  logic       cand_ok;

`ifdef CARD_FILLER_SEED_IN_EN
  localparam bit SEED_LOAD = 1'b1;
  assign lfsr_load_value = (seed == 8'h00) ? LFSR_SEED : seed;
`else
  localparam bit SEED_LOAD = 1'b0;
  assign lfsr_load_value = LFSR_SEED;
`endif

  bingo_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .rstn      (rstn),
    .en        (lfsr_en),
    .load      (lfsr_load),
    .load_value(lfsr_load_value),
    .value     (lfsr_q)
  );

  assign cand_ok = (lfsr_q != 8'h00) && (lfsr_q <= 8'(MAX_NUMBER));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      wr_idx_q   <= '0;
      scan_idx_q <= '0;
      cand_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      scan_idx_q <= scan_idx_d;
      cand_q     <= cand_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    wr_idx_d             = wr_idx_q;
    scan_idx_d           = scan_idx_q;
    cand_d               = cand_q;
    lfsr_en              = 1'b0;
    lfsr_load            = 1'b0;
    ram.ram_addr         = '0;
    ram.ram_write_en     = 1'b0;
    ram.ram_write_number = '0;
    busy                 = 1'b0;
    fill_done            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        lfsr_en = 1'b1;
        if (start_fill) begin
          state_d   = ST_GEN;
          wr_idx_d  = '0;
          lfsr_load = SEED_LOAD;
        end
      end

      ST_GEN: begin
        busy    = 1'b1;
        lfsr_en = 1'b1;
        if (cand_ok) begin
          cand_d = lfsr_q;
          if (wr_idx_q == '0) begin
            state_d = ST_WRITE;
          end else begin
            state_d    = ST_CHECK;
            scan_idx_d = '0;
          end
        end
      end

      ST_CHECK: begin
        busy         = 1'b1;
        ram.ram_addr = scan_idx_q;
        if (ram.ram_read_number == cand_q) begin
          state_d = ST_GEN;
        end else if (scan_idx_q == wr_idx_q - ADDR_WIDTH'(1)) begin
          state_d = ST_WRITE;
        end else begin
          scan_idx_d = scan_idx_q + ADDR_WIDTH'(1);
        end
      end

      ST_WRITE: begin
        busy                 = 1'b1;
        ram.ram_addr         = wr_idx_q;
        ram.ram_write_en     = 1'b1;
        ram.ram_write_number = cand_q;
        if (wr_idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          wr_idx_d = wr_idx_q + ADDR_WIDTH'(1);
          state_d  = ST_GEN;
        end
      end

      ST_DONE: begin
        fill_done = 1'b1;
        // LFSR holds in DONE; a refill without a seed port continues the sequence.
        if (start_fill) begin
          state_d   = ST_GEN;
          wr_idx_d  = '0;
          lfsr_load = SEED_LOAD;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_card_filler.sv
// tb_card_filler: randomized self-checking bench for card_filler.
// A reference model walks the LFSR number sequence, keeps the in-range unique
// values as the card, and derives the per-cycle bus activity from the fill rules.
// Works with and without CARD_FILLER_SEED_IN_EN.
module tb_card_filler;

  localparam int N    = 16;
  localparam int MAXN = 99;

`ifdef CARD_FILLER_SEED_IN_EN
  localparam bit SEEDED = 1'b1;
`else
  localparam bit SEEDED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start_fill = 1'b0;
  logic [7:0] seed = 8'h01;
  logic       busy;
  logic       fill_done;

  card_filler_if bus ();

  card_filler dut (
    .clk       (clk),
    .rstn      (rstn),
    .start_fill(start_fill),
`ifdef CARD_FILLER_SEED_IN_EN
    .seed      (seed),
`endif
    .ram       (bus),
    .busy      (busy),
    .fill_done (fill_done)
  );

  always #5 clk = ~clk;

  // Bench RAM, with an optional poisoned slot to force the duplicate path.
  logic [7:0] mem [N];
  logic       poison_en = 1'b0;
  logic [3:0] poison_addr = 4'd0;
  logic [7:0] poison_val = 8'd0;

  assign bus.ram_read_number = (poison_en && bus.ram_addr == poison_addr) ? poison_val
                                                                          : mem[bus.ram_addr];
  always @(posedge clk) if (bus.ram_write_en) mem[bus.ram_addr] <= bus.ram_write_number;

  int total = 0;
  int bad   = 0;

  logic [14:0] exp_q [$];
  logic [7:0]  card [$];
  int          first_chk;

  function automatic logic [7:0] nxt(input logic [7:0] l);
    return (l >> 1) ^ (((l % 2) == 1) ? 8'd184 : 8'd0);
  endfunction

  function automatic logic [14:0] row(input bit b, input bit d, input bit we,
                                      input int a, input int v);
    return {b, d, we, 4'(a), 8'(v)};
  endfunction

  function automatic logic [14:0] obs();
    return {busy, fill_done, bus.ram_write_en, bus.ram_addr, bus.ram_write_number};
  endfunction

  function automatic logic [7:0] seen(input int j);
    if (poison_en && j == int'(poison_addr)) return poison_val;
    return card[j];
  endfunction

  function automatic logic [7:0] start_l(input logic [7:0] lin, input bit from_idle);
    if (SEEDED) return (seed == 8'h00) ? 8'h01 : seed;
    return from_idle ? nxt(lin) : lin;
  endfunction

  function automatic logic [7:0] nth_in_range(input logic [7:0] l0, input int n);
    logic [7:0] l = l0;
    int k = 0;
    for (int i = 0; i < 255; i++) begin
      if (l >= 1 && l <= MAXN) begin
        k++;
        if (k == n) return l;
      end
      l = nxt(l);
    end
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected rows, one per cycle after the start edge, ending with the first DONE cycle.
  task automatic build_expect(input logic [7:0] l0, output logic [7:0] lf);
    logic [7:0] l, c;
    int size, d;
    exp_q.delete();
    card.delete();
    first_chk = -1;
    l = l0;
    size = 0;
    while (size < N) begin
      c = l;
      l = nxt(l);
      exp_q.push_back(row(1, 0, 0, 0, 0));
      if (c < 1 || c > MAXN) continue;
      d = -1;
      for (int j = 0; j < size; j++) begin
        if (first_chk < 0) first_chk = exp_q.size();
        exp_q.push_back(row(1, 0, 0, j, 0));
        if (seen(j) == c) begin
          d = j;
          break;
        end
      end
      if (d >= 0) continue;
      exp_q.push_back(row(1, 0, 1, size, c));
      card.push_back(c);
      size++;
    end
    exp_q.push_back(row(0, 1, 0, 0, 0));
    lf = l;
  endtask

  task automatic run_fill(input string name, input logic [7:0] lin, input bit from_idle,
                          input bit keep, input bit stop_in_check, output logic [7:0] lf);
    build_expect(start_l(lin, from_idle), lf);
    start_fill = 1'b1;
    for (int t = 0; t < exp_q.size(); t++) begin
      step();
      if (!keep) start_fill = 1'b0;
      chk($sformatf("%s row%0d", name, t), 32'(obs()), 32'(exp_q[t]));
      if (stop_in_check && t == first_chk) return;
    end
  endtask

  task automatic check_card(input string name);
    logic [99:0] hit = '0;
    for (int j = 0; j < N; j++) begin
      chk($sformatf("%s mem%0d", name, j), 32'(mem[j]), 32'(card[j]));
      chk($sformatf("%s range%0d", name, j), 32'(mem[j] >= 1 && mem[j] <= MAXN), 32'd1);
      if (mem[j] <= MAXN) begin
        chk($sformatf("%s unique%0d", name, j), 32'(hit[mem[j]]), 32'd0);
        hit[mem[j]] = 1'b1;
      end
    end
  endtask

  task automatic idle_steps(input int k, inout logic [7:0] lm, input string name);
    for (int i = 0; i < k; i++) begin
      step();
      lm = nxt(lm);
      chk($sformatf("%s idle%0d", name, i), 32'(obs()), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lm, lf;
    for (int j = 0; j < N; j++) mem[j] = 8'h00;

    // Reset state.
    step();
    chk("reset outputs", 32'(obs()), 32'd0);
    step();
    rstn = 1'b1;
    lm = 8'h01;
    chk("after release", 32'(obs()), 32'd0);

    // Fill from IDLE after a random wait.
    seed = 8'h01;
    idle_steps($urandom_range(0, 20), lm, "wait0");
    run_fill("fill0", lm, 1'b1, 1'b0, 1'b0, lf);
    check_card("card0");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("done hold%0d", i), 32'(obs()), 32'(row(0, 1, 0, 0, 0)));
    end

    // start_fill held through a whole refill: one DONE cycle, then refill again.
    seed = 8'($urandom_range(1, 255));
    run_fill("fill1", lf, 1'b0, 1'b1, 1'b0, lf);
    seed = 8'h00;
    run_fill("fill2", lf, 1'b0, 1'b0, 1'b0, lf);
    check_card("card2");

    // Duplicate path: slot 0 reads back the second candidate.
    seed = 8'($urandom_range(0, 255));
    step();
    poison_addr = 4'd0;
    poison_val  = nth_in_range(start_l(lf, 1'b0), 2);
    poison_en   = 1'b1;
    run_fill("fill3", lf, 1'b0, 1'b0, 1'b0, lf);
    poison_en = 1'b0;
    check_card("card3");

    // Reset while scanning.
    seed = 8'($urandom_range(0, 255));
    run_fill("fill4", lf, 1'b0, 1'b0, 1'b1, lf);
    #2 rstn = 1'b0;
    #1 chk("async reset", 32'(obs()), 32'd0);
    step();
    chk("reset edge", 32'(obs()), 32'd0);
    rstn = 1'b1;
    lm = 8'h01;
    idle_steps(4 + $urandom_range(0, 10), lm, "wait5");

    // Fresh fill after reset.
    seed = 8'($urandom_range(0, 255));
    run_fill("fill5", lm, 1'b1, 1'b0, 1'b0, lf);
    check_card("card5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
